// File: rtl/alu_rf_board_sequencer_pkg.sv
// Shared types and constants for the ALU/register-file board sequencer.
package alu_rf_board_pkg;

  localparam int ALU_OP_WIDTH   = 3;
  localparam int FLAG_LED_WIDTH = 5;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ISSUE,
    CAPTURE
  } seqState_t;

endpackage

// File: rtl/alu_rf_board_sequencer_if.sv
// Control/result bus between the board sequencer (master) and the ALUandRF datapath (slave).
interface alu_rf_board_sequencer_if
  import alu_rf_board_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0]   srcAddr;
  logic [ADDR_WIDTH-1:0]   dstAddr;
  logic [WIDTH-1:0]        immd;
  logic [ALU_OP_WIDTH-1:0] aluOpOut;
  logic                    rTypeInstruction;
  logic                    copyInstruction;
  logic                    regWrite;
  logic                    flagSet;
  logic                    pcInstruction;
  logic                    shiftInstruction;
  logic [WIDTH-1:0]        resultData;
  logic [WIDTH-1:0]        outputFlags;

  modport master (
    output srcAddr, dstAddr, immd, aluOpOut,
    output rTypeInstruction, copyInstruction, regWrite, flagSet,
    output pcInstruction, shiftInstruction,
    input  resultData, outputFlags
  );

  modport slave (
    input  srcAddr, dstAddr, immd, aluOpOut,
    input  rTypeInstruction, copyInstruction, regWrite, flagSet,
    input  pcInstruction, shiftInstruction,
    output resultData, outputFlags
  );

endinterface

// File: rtl/alu_rf_board_sequencer_button_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, optional debouncer, rising-edge pulse.
// Define ALURF_SEQ_DEBOUNCE_EN to enable the stable-level debounce filter.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic buttonRaw,
  output logic stepPulse
);

  logic syncStage1;
  logic syncLevel;
  logic filteredLevel;
  logic prevLevel;

  // Bring the asynchronous button into the clock domain through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncStage1 <= 1'b0;
      syncLevel  <= 1'b0;
    end else begin
      syncStage1 <= buttonRaw;
      syncLevel  <= syncStage1;
    end
  end

`ifdef ALURF_SEQ_DEBOUNCE_EN
  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] stableCount;

  // Accept a new level only after it has differed from the filtered level for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filteredLevel <= 1'b0;
      stableCount   <= '0;
    end else if (syncLevel == filteredLevel) begin
      stableCount <= '0;
    end else if (stableCount == LAST_COUNT) begin
      filteredLevel <= syncLevel;
      stableCount   <= '0;
    end else begin
      stableCount <= stableCount + 1'b1;
    end
  end
`else
  assign filteredLevel = syncLevel;
`endif

  // Remember the previous filtered level so a rising edge yields a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevLevel <= 1'b0;
    end else begin
      prevLevel <= filteredLevel;
    end
  end

  assign stepPulse = filteredLevel & ~prevLevel;

endmodule

// File: rtl/alu_rf_board_sequencer.sv
// Board exerciser for the ALUandRF datapath: seeds all registers, then runs one
// R-type operation per button press and pages the captured result onto the LEDs.
// Define ALURF_SEQ_DEBOUNCE_EN to debounce the step button.
module alu_rf_board_sequencer
  import alu_rf_board_pkg::*;
#(
  parameter int          WIDTH           = 16,
  parameter int          ADDR_WIDTH      = 4,
  parameter int          LED_WIDTH       = 10,
  parameter int unsigned SEED            = 1,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     srcAddrSwitches,
  input  logic [ADDR_WIDTH-1:0]     dstAddrSwitches,
  input  logic [ALU_OP_WIDTH-1:0]   aluOp,
  input  logic                      writeEnSwitch,
  input  logic                      pageSwitch,
  input  logic                      stepButton,
  output logic [LED_WIDTH-1:0]      resultDataLeds,
  output logic [FLAG_LED_WIDTH-1:0] flagLeds,
  output logic                      busy,
  alu_rf_board_sequencer_if.master  dp
);

  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] INIT_DONE = CNT_WIDTH'(NUM_REGS);
  localparam logic [WIDTH-1:0]     SEED_W    = WIDTH'(SEED);

  seqState_t state, nextState;
  logic [CNT_WIDTH-1:0] initCount, nextInitCount;

  // The registered datapath outputs double as the holding registers for the sampled switches.
  logic [ADDR_WIDTH-1:0]   srcAddrReg, nextSrcAddr;
  logic [ADDR_WIDTH-1:0]   dstAddrReg, nextDstAddr;
  logic [WIDTH-1:0]        immdReg, nextImmd;
  logic [ALU_OP_WIDTH-1:0] aluOpReg, nextAluOp;
  logic rTypeReg, nextRType;
  logic copyReg, nextCopy;
  logic regWriteReg, nextRegWrite;
  logic flagSetReg, nextFlagSet;
  logic busyReg;

  logic [WIDTH-1:0]          capturedResult;
  logic [FLAG_LED_WIDTH-1:0] capturedFlags;
  logic [WIDTH+LED_WIDTH-1:0] capturedWide;
  logic stepPulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uButton (
    .clk      (clk),
    .reset    (reset),
    .buttonRaw(stepButton),
    .stepPulse(stepPulse)
  );

  // State, init counter and all datapath-facing outputs are registered from their next values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      initCount   <= '0;
      srcAddrReg  <= '0;
      dstAddrReg  <= '0;
      immdReg     <= '0;
      aluOpReg    <= '0;
      rTypeReg    <= 1'b0;
      copyReg     <= 1'b0;
      regWriteReg <= 1'b0;
      flagSetReg  <= 1'b0;
      busyReg     <= 1'b1;
    end else begin
      state       <= nextState;
      initCount   <= nextInitCount;
      srcAddrReg  <= nextSrcAddr;
      dstAddrReg  <= nextDstAddr;
      immdReg     <= nextImmd;
      aluOpReg    <= nextAluOp;
      rTypeReg    <= nextRType;
      copyReg     <= nextCopy;
      regWriteReg <= nextRegWrite;
      flagSetReg  <= nextFlagSet;
      busyReg     <= (nextState != IDLE);
    end
  end

  // Next-state and next-output logic; strobes default low, addresses and data hold.
  always_comb begin
    nextState     = state;
    nextInitCount = initCount;
    nextSrcAddr   = srcAddrReg;
    nextDstAddr   = dstAddrReg;
    nextImmd      = immdReg;
    nextAluOp     = aluOpReg;
    nextRType     = 1'b0;
    nextCopy      = 1'b0;
    nextRegWrite  = 1'b0;
    nextFlagSet   = 1'b0;
    case (state)
      INIT: begin
        if (initCount != INIT_DONE) begin
          nextDstAddr   = initCount[ADDR_WIDTH-1:0];
          nextImmd      = SEED_W + WIDTH'(initCount);
          nextCopy      = 1'b1;
          nextRegWrite  = 1'b1;
          nextInitCount = initCount + 1'b1;
        end else begin
          nextDstAddr = '0;
          nextImmd    = '0;
          nextState   = IDLE;
        end
      end
      IDLE: begin
        if (stepPulse) begin
          nextSrcAddr  = srcAddrSwitches;
          nextDstAddr  = dstAddrSwitches;
          nextAluOp    = aluOp;
          nextRType    = 1'b1;
          nextFlagSet  = 1'b1;
          nextRegWrite = writeEnSwitch;
          nextState    = ISSUE;
        end
      end
      ISSUE: begin
        nextState = CAPTURE;
      end
      CAPTURE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = INIT;
      end
    endcase
  end

  // Latch the datapath result and flags on the edge that leaves ISSUE, alongside any register write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capturedResult <= '0;
      capturedFlags  <= '0;
    end else if (state == ISSUE) begin
      capturedResult <= dp.resultData;
      capturedFlags  <= dp.outputFlags[FLAG_LED_WIDTH-1:0];
    end
  end

  assign capturedWide = {{LED_WIDTH{1'b0}}, capturedResult};

  // Show the selected LED page; the upper page is zero-extended and empty when WIDTH <= LED_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resultDataLeds <= '0;
    end else if (pageSwitch) begin
      resultDataLeds <= LED_WIDTH'(capturedWide >> LED_WIDTH);
    end else begin
      resultDataLeds <= capturedWide[LED_WIDTH-1:0];
    end
  end

  assign flagLeds            = capturedFlags;
  assign busy                = busyReg;
  assign dp.srcAddr          = srcAddrReg;
  assign dp.dstAddr          = dstAddrReg;
  assign dp.immd             = immdReg;
  assign dp.aluOpOut         = aluOpReg;
  assign dp.rTypeInstruction = rTypeReg;
  assign dp.copyInstruction  = copyReg;
  assign dp.regWrite         = regWriteReg;
  assign dp.flagSet          = flagSetReg;
  assign dp.pcInstruction    = 1'b0;
  assign dp.shiftInstruction = 1'b0;

endmodule
